// File: rtl/blackjack_pkg.sv
// Shared blackjack definitions: card field layout, deck size and fill values.
// Used by deck_ctrl, deck_ram and the draw engine.
package blackjack_pkg;

    localparam int NUM_CARDS = 52;
    localparam int NUM_RANKS = 13;

    localparam int SUIT_MSB = 6;
    localparam int SUIT_LSB = 5;
    localparam int USED_BIT = 4;
    localparam int RANK_MSB = 3;
    localparam int RANK_LSB = 0;

    localparam logic [6:0] USED_CARD = 7'h10;

    typedef enum logic {
        SWEEP,
        READY
    } deck_state_t;

    function automatic logic [6:0] make_card(
        input logic [5:0] index,
        input int         nranks
    );
        make_card = {2'(int'(index) / nranks),
                     1'b0,
                     4'(int'(index) % nranks + 1)};
    endfunction

endpackage

// File: rtl/deck_ram.sv
// Deck storage: one write port, a registered read port and a
// combinational used-bit peek for card accounting.
module deck_ram #(
    parameter int NUM_CARDS = 52
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_we,
    input  logic [5:0] i_waddr,
    input  logic [6:0] i_wdata,
    input  logic       i_re,
    input  logic [5:0] i_raddr,
    input  logic       i_rblock,
    output logic [6:0] o_rdata,
    input  logic [5:0] i_paddr,
    output logic       o_pused
);
    import blackjack_pkg::*;

    logic [6:0] r_mem [NUM_CARDS];
    logic [6:0] r_rdata;
    logic       w_win;
    logic       w_rin;
    logic       w_pin;

    assign w_win = i_waddr < 6'(NUM_CARDS);
    assign w_rin = i_raddr < 6'(NUM_CARDS);
    assign w_pin = i_paddr < 6'(NUM_CARDS);

    // Contents are deliberately not reset; the sweep rewrites them.
    always_ff @(posedge clk) begin
        if (i_we && w_win) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 7'h00;
        end else if (i_re) begin
            if (i_rblock || !w_rin) begin
                r_rdata <= USED_CARD;
            end else begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_pused = w_pin ? r_mem[i_paddr][USED_BIT] : 1'b1;

endmodule

// File: rtl/deck_ctrl.sv
// Deck owner: refill sweep FSM, draw-port arbitration and unused-card count.
// Optional DECK_AUTO_REFILL_EN starts a new sweep when the deck runs out.
module deck_ctrl #(
    parameter int NUM_CARDS = 52,
    parameter int NUM_RANKS = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] deck_addr,
    input  logic       deck_read_en,
    input  logic       deck_write_en,
    input  logic [6:0] deck_write_data,
    output logic [6:0] deck_read_data,
    input  logic       new_deck,
    output logic       busy,
    output logic [5:0] cards_left,
    output logic       deck_empty
);
    import blackjack_pkg::*;

    deck_state_t r_state;
    deck_state_t w_state_nxt;
    logic [5:0]  r_idx;
    logic [5:0]  w_idx_nxt;
    logic [5:0]  r_cards;
    logic [5:0]  w_cards_nxt;

    logic       w_sweep;
    logic       w_in_range;
    logic       w_auto;
    logic       w_refill;
    logic       w_draw_we;
    logic       w_ram_we;
    logic [5:0] w_ram_waddr;
    logic [6:0] w_ram_wdata;
    logic       w_old_used;
    logic       w_new_used;

    assign w_sweep    = (r_state == SWEEP);
    assign w_in_range = deck_addr < 6'(NUM_CARDS);

`ifdef DECK_AUTO_REFILL_EN
    assign w_auto = (r_state == READY) && (r_cards == 6'd0);
`else
    assign w_auto = 1'b0;
`endif

    assign w_refill  = new_deck || w_auto;
    assign w_draw_we = !w_sweep && deck_write_en && !w_refill && w_in_range;

    assign w_ram_we    = w_sweep || w_draw_we;
    assign w_ram_waddr = w_sweep ? r_idx : deck_addr;
    assign w_ram_wdata = w_sweep ? make_card(r_idx, NUM_RANKS)
                                 : deck_write_data;

    deck_ram #(
        .NUM_CARDS (NUM_CARDS)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_ram_we),
        .i_waddr  (w_ram_waddr),
        .i_wdata  (w_ram_wdata),
        .i_re     (deck_read_en),
        .i_raddr  (deck_addr),
        .i_rblock (w_sweep),
        .o_rdata  (deck_read_data),
        .i_paddr  (deck_addr),
        .o_pused  (w_old_used)
    );

    assign w_new_used = deck_write_data[USED_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SWEEP;
            r_idx   <= 6'd0;
            r_cards <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cards <= w_cards_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cards_nxt = r_cards;
        if (w_refill) begin
            w_state_nxt = SWEEP;
            w_idx_nxt   = 6'd0;
            w_cards_nxt = 6'd0;
        end else begin
            unique case (r_state)
                SWEEP: begin
                    if (r_idx == 6'(NUM_CARDS - 1)) begin
                        w_state_nxt = READY;
                        w_idx_nxt   = 6'd0;
                        w_cards_nxt = 6'(NUM_CARDS);
                    end else begin
                        w_idx_nxt = r_idx + 6'd1;
                    end
                end
                READY: begin
                    // Count only used-bit transitions so rewrites are neutral.
                    if (w_draw_we && !w_old_used && w_new_used) begin
                        w_cards_nxt = r_cards - 6'd1;
                    end else if (w_draw_we && w_old_used && !w_new_used) begin
                        w_cards_nxt = r_cards + 6'd1;
                    end
                end
                default: begin
                    w_state_nxt = SWEEP;
                end
            endcase
        end
    end

    assign busy       = w_sweep;
    assign cards_left = r_cards;
    assign deck_empty = (r_state == READY) && (r_cards == 6'd0);

endmodule

// File: tb/tb_deck_ctrl.sv
// Scoreboard bench for deck_ctrl: reads queue expected data, a monitor
// compares it one cycle later; status outputs are checked directly.
module tb_deck_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] deck_addr = '0;
    logic       deck_read_en = 1'b0;
    logic       deck_write_en = 1'b0;
    logic [6:0] deck_write_data = '0;
    logic [6:0] deck_read_data;
    logic       new_deck = 1'b0;
    logic       busy;
    logic [5:0] cards_left;
    logic       deck_empty;

    int errors = 0;
    int checks = 0;

    logic [6:0] exp_q [$];
    logic       rd_v = 1'b0;

    always #5 clk = ~clk;

    deck_ctrl #(
        .NUM_CARDS (52),
        .NUM_RANKS (13)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .deck_addr       (deck_addr),
        .deck_read_en    (deck_read_en),
        .deck_write_en   (deck_write_en),
        .deck_write_data (deck_write_data),
        .deck_read_data  (deck_read_data),
        .new_deck        (new_deck),
        .busy            (busy),
        .cards_left      (cards_left),
        .deck_empty      (deck_empty)
    );

    always @(posedge clk) rd_v <= deck_read_en;

    always @(negedge clk) begin
        if (rd_v) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %02h with empty queue",
                         deck_read_data);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if (deck_read_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %02h expected %02h",
                             deck_read_data, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [5:0] a, input logic [6:0] e);
        deck_addr    = a;
        deck_read_en = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        deck_read_en = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [6:0] d);
        deck_addr       = a;
        deck_write_data = d;
        deck_write_en   = 1'b1;
        @(negedge clk);
        deck_write_en = 1'b0;
    endtask

    task automatic pulse_new_deck();
        new_deck = 1'b1;
        @(negedge clk);
        new_deck = 1'b0;
    endtask

    // Counts edges until busy falls; optionally pokes addr 3 mid-sweep.
    task automatic count_busy(input string nm, input bit inject);
        int n;
        n = 0;
        do begin
            if (inject && n == 5) begin
                deck_addr       = 6'd3;
                deck_read_en    = 1'b1;
                deck_write_en   = 1'b1;
                deck_write_data = 7'h13;
                exp_q.push_back(7'h10);
            end
            @(negedge clk);
            deck_read_en  = 1'b0;
            deck_write_en = 1'b0;
            n++;
        end while (busy && n < 200);
        chk({nm, "_len"}, n, 52);
        chk({nm, "_cards"}, int'(cards_left), 52);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 1);
        chk("rst_cards", int'(cards_left), 0);
        chk("rst_empty", int'(deck_empty), 0);
        chk("rst_rdata", int'(deck_read_data), 0);
        rst = 1'b0;
        count_busy("sweep0", 1'b0);
        chk("ready_empty", int'(deck_empty), 0);

        rd(6'd0, 7'h01);
        rd(6'd12, 7'h0D);
        rd(6'd13, 7'h21);
        rd(6'd51, 7'h6D);

        wr(6'd5, 7'h16);
        chk("draw5_cards", int'(cards_left), 51);
        wr(6'd5, 7'h16);
        chk("redraw5_cards", int'(cards_left), 51);
        rd(6'd5, 7'h16);
        wr(6'd5, 7'h06);
        chk("return5_cards", int'(cards_left), 52);

        rd(6'd60, 7'h10);
        wr(6'd60, 7'h16);
        chk("oor_cards", int'(cards_left), 52);

        // Same-cycle read and write returns the old value.
        deck_addr       = 6'd7;
        deck_write_data = 7'h18;
        deck_read_en    = 1'b1;
        deck_write_en   = 1'b1;
        exp_q.push_back(7'h08);
        @(negedge clk);
        deck_read_en  = 1'b0;
        deck_write_en = 1'b0;
        chk("rw7_cards", int'(cards_left), 51);
        rd(6'd7, 7'h18);

        // new_deck beats a same-cycle draw write.
        deck_addr       = 6'd9;
        deck_write_data = 7'h1A;
        deck_write_en   = 1'b1;
        new_deck        = 1'b1;
        @(negedge clk);
        deck_write_en = 1'b0;
        new_deck      = 1'b0;
        chk("nd_busy", int'(busy), 1);
        chk("nd_cards", int'(cards_left), 0);
        chk("nd_empty", int'(deck_empty), 0);
        count_busy("sweep_nd", 1'b1);
        rd(6'd3, 7'h04);
        rd(6'd7, 7'h08);
        rd(6'd9, 7'h0A);

        pulse_new_deck();
        repeat (20) @(negedge clk);
        pulse_new_deck();
        count_busy("sweep_restart", 1'b0);

        pulse_new_deck();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_cards", int'(cards_left), 0);
        rst = 1'b0;
        count_busy("sweep_rst", 1'b0);

        for (int i = 0; i < 51; i++) wr(6'(i), 7'h10);
        chk("one_left", int'(cards_left), 1);
        chk("one_left_empty", int'(deck_empty), 0);
        wr(6'd51, 7'h10);
        chk("drained_cards", int'(cards_left), 0);
        chk("drained_empty", int'(deck_empty), 1);
        chk("drained_busy", int'(busy), 0);
        @(negedge clk);
`ifdef DECK_AUTO_REFILL_EN
        chk("auto_empty_drop", int'(deck_empty), 0);
        chk("auto_busy", int'(busy), 1);
        count_busy("sweep_auto", 1'b0);
`else
        chk("hold_empty", int'(deck_empty), 1);
        chk("hold_busy", int'(busy), 0);
        rd(6'd20, 7'h10);
        pulse_new_deck();
        chk("refill_empty", int'(deck_empty), 0);
        count_busy("sweep_refill", 1'b0);
`endif
        rd(6'd20, 7'h28);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/deck_ctrl.md
# deck_ctrl

Owner and arbiter of the 52-entry card deck memory used by the blackjack game. It holds the deck storage and fills it with a fresh, ordered deck after reset or on a `new_deck` command. It then serves the draw port (card_draw) with registered reads and used-bit writes. It tracks the number of unused cards and flags an exhausted deck so the game FSM never lets the draw engine spin forever.

## Interface
Parameters:
- `NUM_CARDS`, default 52: deck entries; valid addresses are 0..NUM_CARDS-1.
- `NUM_RANKS`, default 13: ranks per suit.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `deck_addr`  in  6  draw-port address.
- `deck_read_en`  in  1  draw-port read strobe.
- `deck_write_en`  in  1  draw-port write strobe.
- `deck_write_data`  in  7  draw-port write data.
- `deck_read_data`  out  7  registered read data; holds until the next accepted read.
- `new_deck`  in  1  single-cycle request to refill the deck.
- `busy`  out  1  refill sweep in progress.
- `cards_left`  out  6  count of entries with the used bit clear.
- `deck_empty`  out  1  deck ready and `cards_left` == 0.

## Operation
- Card encoding: [6:5] suit, [4] used, [3:0] rank 1..13.
- Fill value for index i: suit = i / NUM_RANKS, used = 0, rank = i % NUM_RANKS + 1.
- FSM state SWEEP:
  - Sweep index 0..NUM_CARDS-1 writes one fill value per cycle.
  - Draw-port reads return 7'h10 (used set), which forces card_draw to retry.
  - Draw-port writes are dropped.
  - After index NUM_CARDS-1 is written, go to READY and load `cards_left` = NUM_CARDS.
- FSM state READY:
  - A read updates `deck_read_data` with the array contents.
  - A write updates the array entry.
  - `cards_left` decrements when the old used bit is 0 and the new used bit is 1.
  - `cards_left` increments when the old used bit is 1 and the new used bit is 0.
  - Otherwise `cards_left` is unchanged.
- `new_deck` in either state: the next state is SWEEP with index 0 and `cards_left` = 0.
  - In SWEEP this restarts the sweep.
  - A same-cycle draw write is dropped (`new_deck` wins).
- Out-of-range address (>= NUM_CARDS): reads return 7'h10; writes are ignored.
- Read and write to the same address in one cycle: read returns the pre-write value.
- `rst` at any time, including mid-sweep: state SWEEP, index 0. Array contents are not reset; they are rewritten by the sweep.

## Timing
- Reset values: `busy` = 1, `cards_left` = 0, `deck_empty` = 0, `deck_read_data` = 7'h00.
- Sweep length: exactly NUM_CARDS cycles of `busy` = 1 after `rst` deasserts or after the `new_deck` edge.
  - `busy` falls on the same edge that loads `cards_left` = NUM_CARDS.
- Read latency is 1 cycle: data is valid in the cycle after `deck_read_en`, which matches card_draw's check state.
- `cards_left` and `deck_empty` are registered; they reflect a write one cycle after its edge.
- `deck_empty` = 1 only in READY with `cards_left` == 0; it is never asserted while `busy` = 1.

## Configuration
- Macro: `DECK_AUTO_REFILL_EN`.
- Defined: when READY and `cards_left` reaches 0, `deck_empty` is high for exactly one cycle. The controller then enters SWEEP by itself, as if `new_deck` had been asserted.
- Undefined: `deck_empty` stays high until `new_deck` or `rst`.

## Structure
- Shared package `blackjack_pkg`:
  - Card field positions: SUIT_MSB/LSB, USED_BIT, RANK_MSB/LSB.
  - NUM_CARDS.
  - USED_CARD constant 7'h10.
  - `deck_state_t` enum {SWEEP, READY}.
  - Function `make_card(index)` that returns the fill value.
- Sub-module `deck_ram`: NUM_CARDS x 7 register array with one write port, a registered read port, and a combinational peek port used for used-bit accounting.
- `deck_ctrl` contains the FSM, the sweep counter, the port mux/arbitration, and the counter/flag logic.

## Test plan
- Release `rst` -> `busy` = 1 for 52 cycles, then `cards_left` = 52. Reads then return:
  - addr 0 -> 7'h01
  - addr 12 -> 7'h0D
  - addr 13 -> 7'h21
  - addr 51 -> 7'h6D
- READY, write addr 5 with 7'h16 -> `cards_left` = 51; the same write again leaves it at 51; a read of addr 5 returns 7'h16.
- During the sweep, read addr 3 -> 7'h10. A write to addr 3 with 7'h13 is dropped: after the sweep, addr 3 reads 7'h04.
- Drive card_draw until 52 cards are drawn -> `deck_empty` = 1 one cycle after the last write.
  - Without the macro it stays high; `new_deck` -> 52 busy cycles -> `cards_left` = 52.
  - With the macro, `deck_empty` pulses one cycle and `busy` rises.
- `new_deck` at sweep index 20, or `rst` mid-sweep -> the sweep restarts at 0, giving 52 busy cycles counted from the restart.
- READY, read/write addr 60 -> reads return 7'h10; `cards_left` is unchanged. `new_deck` in the same cycle as a draw write drops the write.
